fpu_rr_scheduler: RTL
=====================

Name: fpu_rr_scheduler

Overview:
- Shares one FPU instance (2-cycle pipeline: inputs registered, result registered on the following edge) between NUM_REQ requesters.
- Round-robin arbitration; one operation in flight at a time; result returned to the granted requester with a valid/ready handshake.
- Sits between the AXI-Lite register front-ends (or other masters) and the FPU core; owns fpu_start sequencing and operand stability.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- FPU_LATENCY, 2, cycles from the fpu_start cycle to the cycle fpu_o is valid (>=1)
- IDX_W, $clog2(NUM_REQ), requester index width (derived; do not override)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester operation request
- req_ready  out  NUM_REQ  per-requester accept pulse (one-hot or zero)
- req_a  in  NUM_REQ*32  operand A, requester i at [32*i+31:32*i]
- req_b  in  NUM_REQ*32  operand B, same packing
- req_opcode  in  NUM_REQ*2  00 add, 01 sub, 10 mul, 11 div
- rsp_valid  out  NUM_REQ  result valid, one-hot to the owning requester
- rsp_ready  in  NUM_REQ  per-requester result accept
- rsp_data  out  32  result word (shared bus)
- fpu_start  out  1  to FPU start
- fpu_a  out  32  to FPU A
- fpu_b  out  32  to FPU B
- fpu_opcode  out  2  to FPU opcode
- fpu_o  in  32  from FPU O
- busy  out  1  high in any state other than IDLE
- ops_done  out  16  count of completed responses (wraps 0xFFFF->0)

Behaviour:
- Reset: the synchronous reset is active-high, on clk (rst). All outputs become 0, state IDLE, rr_ptr 0, cnt 0, ops_done 0. Reset mid-operation aborts the operation. The in-flight result is discarded and never presented.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - If a winner exists: req_ready[winner]=1 in the same cycle (combinational from req_valid and rr_ptr). Latch the winner's a/b/opcode into fpu_a/fpu_b/fpu_opcode registers and latch gnt_idx. Go to ISSUE.
  - If no requester is valid: stay in IDLE, req_ready=0.
- ISSUE (1 cycle): fpu_start=1; cnt <= FPU_LATENCY-1; go to WAIT.
- WAIT:
  - fpu_start=0.
  - If cnt==0: capture fpu_o into rsp_data and go to RESP; else cnt <= cnt-1.
  - fpu_a/b/opcode hold stable from ISSUE through the end of WAIT.
- RESP:
  - rsp_valid[gnt_idx]=1; rsp_data held stable.
  - On rsp_ready[gnt_idx]: rsp_valid <= 0; ops_done++; rr_ptr <= gnt_idx+1 (wrap NUM_REQ-1 -> 0); go to IDLE.
  - rsp_ready of other requesters is ignored.
- Timing: accept in cycle c -> ISSUE c+1 -> rsp_valid asserted c+2+FPU_LATENCY (c+4 at default). Minimum spacing between accepts is FPU_LATENCY+3 cycles.
- req_ready is only ever asserted in IDLE; never more than one bit set.
- Requesters hold req_valid and payload until req_ready. Dropping valid before accept is legal; the request simply is not granted.
- No combinational path from rsp_ready to req_ready: IDLE is always re-entered for at least one cycle before the next grant.
- fpu_opcode and operands are passed through unmodified; special-value handling belongs to the FPU.

Test Plan:
- After reset, req_valid=0001, req_a[0]=0x3F800000, req_b[0]=0x40000000, opcode 00, accepted cycle c -> fpu_start pulses in c+1 only; rsp_valid=0001 at c+4; rsp_data=0x40400000; ops_done=1 after rsp_ready.
- req_valid=1111 held continuously with rsp_ready=1111 -> grant order 0,1,2,3,0,1; each req_ready one-hot; accepts spaced exactly 5 cycles apart.
- Serve requester 2, then req_valid=1010 -> requester 3 granted before requester 1.
- Hold rsp_ready[1]=0 for 6 cycles during RESP for requester 1 -> rsp_valid=0010 and rsp_data stable; req_ready=0 and fpu_start=0 throughout; completes the cycle after rsp_ready[1]=1.
- Assert rst during WAIT -> next cycle busy=0, all outputs 0, rr_ptr 0; the aborted result never appears on rsp_valid. A fresh request from requester 0 is then granted first.
- FPU_LATENCY=3 with a stub FPU model; MUL 0x40000000*0x40400000 -> rsp_data=0x40C00000 at c+5. A wrong-latency capture returns the stub's stale value, so the bench must check this.

Source files
------------

// File: rtl/fpu_rr_scheduler.sv
// fpu_rr_scheduler
//   Round-robin front end for a single shared FPU. It grants one requester
//   at a time, launches the operation, waits out the FPU latency, and
//   returns the result to the granted requester with a valid/ready
//   handshake.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   per-requester request handshake (ready is one-hot or 0)
//   req_a/b/opcode    packed per-requester operands (32/32/2 bits each)
//   rsp_valid/ready   per-requester result handshake (valid is one-hot or 0)
//   rsp_data          shared result bus
//   fpu_start/a/b/
//   fpu_opcode/fpu_o  FPU core interface
//   busy              high whenever not IDLE
//   ops_done          completed response count (wraps)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | arbitrate; grant the first valid requester starting at rr_ptr
// ISSUE | fpu_start pulse; operands already latched
// WAIT  | count down FPU latency, capture fpu_o at terminal count
// RESP  | present result to the granted requester until it accepts
module fpu_rr_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int FPU_LATENCY = 2,
  parameter int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  input  logic [NUM_REQ*2-1:0]   req_opcode,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [31:0]            rsp_data,
  output logic                   fpu_start,
  output logic [31:0]            fpu_a,
  output logic [31:0]            fpu_b,
  output logic [1:0]             fpu_opcode,
  input  logic [31:0]            fpu_o,
  output logic                   busy,
  output logic [15:0]            ops_done
);

  localparam int CNT_W = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e               state_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     gnt_idx_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [31:0]          fpu_a_q;
  logic [31:0]          fpu_b_q;
  logic [1:0]           fpu_op_q;
  logic                 fpu_start_q;
  logic [31:0]          rsp_data_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [15:0]          ops_done_q;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     cand_idx;
  logic                 grant;
  logic [IDX_W-1:0]     rr_ptr_d;

  // Rotating priority search starting at rr_ptr; first hit wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Grant only from IDLE, and never while reset is being applied, so an
  // accept pulse cannot be seen for a request that reset will discard.
  assign grant     = (state_q == IDLE) && win_found && !rst;
  assign req_ready = grant ? (ONE_HOT0 << win_idx) : '0;

  assign rr_ptr_d  = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_idx_q   <= '0;
      cnt_q       <= '0;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      fpu_op_q    <= '0;
      fpu_start_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
      ops_done_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            fpu_a_q     <= req_a[32*win_idx +: 32];
            fpu_b_q     <= req_b[32*win_idx +: 32];
            fpu_op_q    <= req_opcode[2*win_idx +: 2];
            gnt_idx_q   <= win_idx;
            fpu_start_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          fpu_start_q <= 1'b0;
          cnt_q       <= CNT_W'(FPU_LATENCY - 1);
          state_q     <= WAIT;
        end
        WAIT: begin
          if (cnt_q == '0) begin
            rsp_data_q  <= fpu_o;
            rsp_valid_q <= ONE_HOT0 << gnt_idx_q;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          // Only the owning requester's ready completes the response.
          if (rsp_ready[gnt_idx_q]) begin
            rsp_valid_q <= '0;
            ops_done_q  <= ops_done_q + 16'd1;
            rr_ptr_q    <= rr_ptr_d;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign fpu_start  = fpu_start_q;
  assign fpu_a      = fpu_a_q;
  assign fpu_b      = fpu_b_q;
  assign fpu_opcode = fpu_op_q;
  assign busy       = (state_q != IDLE);
  assign ops_done   = ops_done_q;

endmodule
